// File: rtl/mem_access_unit_pkg.sv
// Shared load/store control encodings and FSM state encodings for the MEM-stage access unit.
package mem_access_unit_pkg;

    localparam int MEM_TYPE_LEN  = 3;
    localparam int MEM_WRITE_LEN = 2;

    localparam logic [MEM_TYPE_LEN-1:0] MT_X  = 3'd0;
    localparam logic [MEM_TYPE_LEN-1:0] MT_B  = 3'd1;
    localparam logic [MEM_TYPE_LEN-1:0] MT_H  = 3'd2;
    localparam logic [MEM_TYPE_LEN-1:0] MT_W  = 3'd3;
    localparam logic [MEM_TYPE_LEN-1:0] MT_BU = 3'd5;
    localparam logic [MEM_TYPE_LEN-1:0] MT_HU = 3'd6;

    localparam logic [MEM_WRITE_LEN-1:0] M_X = 2'd0;
    localparam logic [MEM_WRITE_LEN-1:0] M_R = 2'd1;
    localparam logic [MEM_WRITE_LEN-1:0] M_W = 2'd2;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUS  = 2'd1,
        MAU_RESP = 2'd2
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_B    = 2'd1,
        SZ_H    = 2'd2,
        SZ_W    = 2'd3
    } mau_size_e;

    // Signed/unsigned variants collapse to the same access width.
    function automatic mau_size_e mt_size(input logic [MEM_TYPE_LEN-1:0] mt);
        mau_size_e sz;
        case (mt)
            MT_B, MT_BU: sz = SZ_B;
            MT_H, MT_HU: sz = SZ_H;
            MT_W:        sz = SZ_W;
            default:     sz = SZ_NONE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-bus signals of the MEM-stage access unit.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic [MEM_TYPE_LEN-1:0]  memory_type;
    logic [MEM_WRITE_LEN-1:0] memory_rw;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [31:0]              wdata;
    logic                     resp_valid;
    logic                     resp_err;
    logic [31:0]              rdata;
    logic                     bus_req;
    logic                     bus_we;
    logic [ADDR_WIDTH-1:0]    bus_addr;
    logic [3:0]               bus_wstrb;
    logic [31:0]              bus_wdata;
    logic                     bus_ack;
    logic [31:0]              bus_rdata;

    modport slave (
        input  req_valid, memory_type, memory_rw, addr, wdata, bus_ack, bus_rdata,
        output req_ready, resp_valid, resp_err, rdata,
               bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
    );

    modport master (
        output req_valid, memory_type, memory_rw, addr, wdata, bus_ack, bus_rdata,
        input  req_ready, resp_valid, resp_err, rdata,
               bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a bus read word and sign- or zero-extends it.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0]             i_rdata,
    input  logic [1:0]              i_addr,
    input  logic [MEM_TYPE_LEN-1:0] i_type,
    output logic [31:0]             o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = 32'd0;
        case (i_type)
            MT_B:    o_data = {{24{w_byte[7]}}, w_byte};
            MT_BU:   o_data = {24'd0, w_byte};
            MT_H:    o_data = {{16{w_half[15]}}, w_half};
            MT_HU:   o_data = {16'd0, w_half};
            MT_W:    o_data = i_rdata;
            default: o_data = 32'd0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: one access per handshake, word-aligned bus with strobes, bus timeout.
// Optional: define MEM_MISALIGN_TRAP_EN to error misaligned half/word accesses instead of truncating.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
)(
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   mif
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    mau_state_e              r_state, w_state_nxt;
    logic [MEM_TYPE_LEN-1:0] r_type;
    logic [1:0]              r_lane;
    logic [ADDR_WIDTH-1:0]   r_bus_addr;
    logic                    r_we;
    logic [3:0]              r_wstrb;
    logic [31:0]             r_wdata;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                    r_err, w_err_nxt;
    logic [31:0]             r_rdata, w_rdata_nxt;

    mau_size_e   w_size;
    logic        w_is_st, w_nop, w_misalign, w_accept, w_timeout;
    logic [3:0]  w_strb;
    logic [31:0] w_bwdata, w_load_data;

    assign w_size   = mt_size(mif.memory_type);
    assign w_is_st  = (mif.memory_rw == M_W);
    assign w_nop    = ((mif.memory_rw != M_R) && !w_is_st) || (w_size == SZ_NONE);
    assign w_accept = mif.req_valid && (r_state == MAU_IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SZ_H) && mif.addr[0]) ||
                        ((w_size == SZ_W) && (mif.addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Strobes and lane-replicated data; loads drive neither.
    always_comb begin
        w_strb   = 4'b0000;
        w_bwdata = 32'd0;
        if (w_is_st) begin
            case (w_size)
                SZ_B: begin
                    w_strb   = 4'b0001 << mif.addr[1:0];
                    w_bwdata = {4{mif.wdata[7:0]}};
                end
                SZ_H: begin
                    w_strb   = 4'b0011 << {mif.addr[1], 1'b0};
                    w_bwdata = {2{mif.wdata[15:0]}};
                end
                SZ_W: begin
                    w_strb   = 4'b1111;
                    w_bwdata = mif.wdata;
                end
                default: ;
            endcase
        end
    end

    load_extend u_load_extend (
        .i_rdata (mif.bus_rdata),
        .i_addr  (r_lane),
        .i_type  (r_type),
        .o_data  (w_load_data)
    );

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= MAU_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_rdata_nxt = r_rdata;
        case (r_state)
            MAU_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (w_nop || w_misalign) begin
                        w_state_nxt = MAU_RESP;
                        w_err_nxt   = w_misalign;
                        w_rdata_nxt = 32'd0;
                    end else begin
                        w_state_nxt = MAU_BUS;
                    end
                end
            end
            MAU_BUS: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (mif.bus_ack) begin
                    w_state_nxt = MAU_RESP;
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = r_we ? 32'd0 : w_load_data;
                end else if (w_timeout) begin
                    w_state_nxt = MAU_RESP;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = 32'd0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            MAU_RESP: w_state_nxt = MAU_IDLE;
            default:  w_state_nxt = MAU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_type     <= MT_X;
            r_lane     <= 2'b00;
            r_bus_addr <= '0;
            r_we       <= 1'b0;
            r_wstrb    <= 4'b0000;
            r_wdata    <= 32'd0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_type     <= mif.memory_type;
                r_lane     <= mif.addr[1:0];
                r_bus_addr <= {mif.addr[ADDR_WIDTH-1:2], 2'b00};
                r_we       <= w_is_st;
                r_wstrb    <= w_strb;
                r_wdata    <= w_bwdata;
            end
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign mif.req_ready  = (r_state == MAU_IDLE);
    assign mif.resp_valid = (r_state == MAU_RESP);
    assign mif.resp_err   = (r_state == MAU_RESP) && r_err;
    assign mif.rdata      = r_rdata;
    assign mif.bus_req    = (r_state == MAU_BUS);
    assign mif.bus_we     = r_we;
    assign mif.bus_addr   = r_bus_addr;
    assign mif.bus_wstrb  = r_wstrb;
    assign mif.bus_wdata  = r_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit; responses are checked by an independent monitor.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(32)) mif ();

    mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected response.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset && mif.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {31'd0, mif.resp_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_err", {31'd0, mif.resp_err}, {31'd0, e[32]});
                chk("resp_rdata", mif.rdata, e[31:0]);
            end
        end
    end

    // Called just after a rising edge with the unit idle; returns the same way.
    task automatic access(
        input string nm,
        input logic [MEM_TYPE_LEN-1:0] mt, input logic [MEM_WRITE_LEN-1:0] rw,
        input logic [31:0] a, input logic [31:0] wd,
        input int ack_dly, input logic [31:0] brd, input int e_bc,
        input logic [31:0] e_baddr, input logic [3:0] e_strb, input logic e_we,
        input logic [31:0] e_bwd, input logic e_err, input logic [31:0] e_rdata);
        int bc;
        exp_q.push_back({e_err, e_rdata});
        mif.req_valid   = 1'b1;
        mif.memory_type = mt;
        mif.memory_rw   = rw;
        mif.addr        = a;
        mif.wdata       = wd;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!mif.bus_req) break;
            if (bc == 0) begin
                chk({nm, "_bus_addr"}, mif.bus_addr, e_baddr);
                chk({nm, "_wstrb"}, {28'd0, mif.bus_wstrb}, {28'd0, e_strb});
                chk({nm, "_we"}, {31'd0, mif.bus_we}, {31'd0, e_we});
                if (e_we) chk({nm, "_bus_wdata"}, mif.bus_wdata, e_bwd);
            end
            bc++;
            if (ack_dly >= 0 && bc - 1 == ack_dly) begin
                mif.bus_ack   = 1'b1;
                mif.bus_rdata = brd;
            end
            @(posedge clk); #1;
            mif.bus_ack = 1'b0;
        end
        chk({nm, "_bus_cycles"}, bc, e_bc);
        chk({nm, "_resp_latency"}, {31'd0, mif.resp_valid}, 32'd1);
        for (int k = 0; k < 10 && !mif.req_ready; k++) @(negedge clk);
        chk({nm, "_idle"}, {31'd0, mif.req_ready}, 32'd1);
        chk({nm, "_rdata_held"}, mif.rdata, e_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        mif.req_valid   = 1'b0;
        mif.memory_type = MT_X;
        mif.memory_rw   = M_X;
        mif.addr        = 32'd0;
        mif.wdata       = 32'd0;
        mif.bus_ack     = 1'b0;
        mif.bus_rdata   = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, mif.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, mif.resp_valid}, 32'd0);
        chk("rst_bus_req", {31'd0, mif.bus_req}, 32'd0);
        chk("rst_rdata", mif.rdata, 32'd0);
        chk("rst_wstrb", {28'd0, mif.bus_wstrb}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        //     name   type   rw   addr          wdata         dly bus_rdata    bc baddr        strb     we   bus_wdata     err  rdata
        access("lb",  MT_B,  M_R, 32'h103,      32'd0,        2,  32'h80FF1234, 3, 32'h100,     4'b0000, 1'b0, 32'd0,       1'b0, 32'hFFFFFF80);
        access("lhu", MT_HU, M_R, 32'h202,      32'd0,        0,  32'hBEEF0000, 1, 32'h200,     4'b0000, 1'b0, 32'd0,       1'b0, 32'h0000BEEF);
        access("sb",  MT_B,  M_W, 32'h001,      32'h000000A5, 0,  32'hFFFFFFFF, 1, 32'h000,     4'b0010, 1'b1, 32'hA5A5A5A5, 1'b0, 32'd0);
        access("sw_to", MT_W, M_W, 32'h040,     32'h12345678, -1, 32'd0,        4, 32'h040,     4'b1111, 1'b1, 32'h12345678, 1'b1, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        access("lw_mis", MT_W, M_R, 32'h042,    32'd0,        0,  32'hCAFEF00D, 0, 32'h040,     4'b0000, 1'b0, 32'd0,       1'b1, 32'd0);
`else
        access("lw_mis", MT_W, M_R, 32'h042,    32'd0,        0,  32'hCAFEF00D, 1, 32'h040,     4'b0000, 1'b0, 32'd0,       1'b0, 32'hCAFEF00D);
`endif
        access("lh",  MT_H,  M_R, 32'h006,      32'd0,        1,  32'h80017FFF, 2, 32'h004,     4'b0000, 1'b0, 32'd0,       1'b0, 32'hFFFF8001);
        access("lbu", MT_BU, M_R, 32'h002,      32'd0,        0,  32'h00C30000, 1, 32'h000,     4'b0000, 1'b0, 32'd0,       1'b0, 32'h000000C3);
        access("shu", MT_HU, M_W, 32'h00A,      32'h00001234, 0,  32'd0,        1, 32'h008,     4'b1100, 1'b1, 32'h12341234, 1'b0, 32'd0);
        access("nop_mt", MT_X, M_R, 32'h010,    32'd0,        0,  32'd0,        0, 32'd0,       4'b0000, 1'b0, 32'd0,       1'b0, 32'd0);
        access("nop_rw", MT_W, M_X, 32'h010,    32'd0,        0,  32'd0,        0, 32'd0,       4'b0000, 1'b0, 32'd0,       1'b0, 32'd0);

        // Stray ack while idle must not start or complete anything.
        mif.bus_ack   = 1'b1;
        mif.bus_rdata = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clk);
            chk("stray_ack_bus_req", {31'd0, mif.bus_req}, 32'd0);
        end
        @(posedge clk); #1;
        mif.bus_ack = 1'b0;

        // Reset during BUS aborts with no response.
        mif.req_valid   = 1'b1;
        mif.memory_type = MT_W;
        mif.memory_rw   = M_R;
        mif.addr        = 32'h80;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_bus_req_pre", {31'd0, mif.bus_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_bus_req_drop", {31'd0, mif.bus_req}, 32'd0);
        chk("abort_resp_valid", {31'd0, mif.resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_req_ready", {31'd0, mif.req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;

        access("sh_post", MT_H, M_W, 32'h006,   32'h0000BEEF, 0,  32'd0,        1, 32'h004,     4'b1100, 1'b1, 32'hBEEFBEEF, 1'b0, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory responder for the load/store control signals the decoder emits (memory_type, memory_rw); sits in the MEM stage between the ALU address result and the data bus.
- Accepts one access per handshake, converts byte/half/word requests into word-aligned bus transactions with byte strobes, and returns sign- or zero-extended load data.
- Includes a bus-timeout counter.

Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait for bus_ack before an error response; 0 disables the timeout.
- ADDR_WIDTH, 32: byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  access request
- req_ready  out  1  unit can accept; high only in IDLE
- memory_type  in  MEM_TYPE_LEN  MT_B/MT_H/MT_W/MT_BU/MT_HU/MT_X
- memory_rw  in  MEM_WRITE_LEN  M_R/M_W/M_X
- addr  in  ADDR_WIDTH  byte address
- wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: timeout (or misalignment when the feature is enabled)
- rdata  out  32  extended load data; held until next response
- bus_req  out  1  bus transaction active
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_WIDTH  word-aligned address (addr[1:0] = 0)
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion; bus_rdata valid this cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset values (asynchronous): state IDLE, req_ready 1, all other outputs 0, timeout counter 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On req_valid && req_ready, capture all request fields.
  - If memory_rw == M_X or memory_type == MT_X: go to RESP with no bus activity; rdata = 0, resp_err = 0.
  - Otherwise go to BUS.
- BUS:
  - bus_req = 1; bus_we/addr/wstrb/wdata are stable for the whole state.
  - Go to RESP on bus_ack, which counts in the first BUS cycle.
  - Counter increments each cycle without ack. When it reaches TIMEOUT_CYCLES (if nonzero), drop bus_req, go to RESP with resp_err = 1 and rdata = 0.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. Back-to-back accept is the next cycle; no combinational req->ready path.
- Minimum latency: accept at T, bus_req at T+1, ack at T+1, resp_valid at T+2.
- Store strobes:
  - MT_B: wstrb = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - MT_H: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - MT_W: wstrb = 4'b1111.
  - MT_BU/MT_HU on a store are treated as MT_B/MT_H.
  - Store responses return rdata = 0.
- Load extraction from bus_rdata:
  - Lane selected by captured addr[1:0] (byte) or addr[1] (half).
  - MT_B/MT_H sign-extend; MT_BU/MT_HU zero-extend; MT_W passes through.
  - Loads drive wstrb = 0.
- Without the optional feature, misaligned addresses are truncated: the half uses addr[1] only, and the word ignores addr[1:0].
- Reset mid-transaction aborts immediately: bus_req falls asynchronously and no resp_valid is issued.
- bus_ack outside BUS is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, skips BUS and goes to RESP with resp_err = 1, rdata = 0, and no bus activity.
- Undefined: the truncation rule above applies and resp_err is asserted only on timeout.

Decomposition:
- Shared constants stay in the existing control-signal definitions: MEM_TYPE_LEN, MEM_WRITE_LEN, MT_*, M_*.
- New shared constants: MAU_IDLE/MAU_BUS/MAU_RESP state encodings (2 bits).
- One sub-module: load_extend. Combinational; inputs bus_rdata, addr[1:0], memory_type; output 32-bit extended data.
- Strobe generation stays inline.

Test Plan:
- LB at addr 0x103; bus_rdata 0x80FF_1234, ack after 2 cycles -> bus_addr 0x100, wstrb 0, rdata 0xFFFF_FF80, resp_valid 1 cycle, resp_err 0.
- LHU at 0x202; bus_rdata 0xBEEF_0000, immediate ack -> rdata 0x0000_BEEF, resp_valid at T+2.
- SB at 0x001, wdata 0x0000_00A5 -> bus_we 1, wstrb 4'b0010, bus_wdata 0xA5A5_A5A5, rdata 0.
- SW at 0x40 with no ack, TIMEOUT_CYCLES = 4 -> bus_req high 4 cycles then low; resp_valid with resp_err 1.
- LW at 0x42:
  - With MEM_MISALIGN_TRAP_EN: no bus_req, resp_err 1.
  - Without it: bus_addr 0x40, full word returned.
- LW issued, then reset asserted while in BUS -> bus_req 0 same cycle, no resp_valid, req_ready 1 after release; a following SH to 0x6 gets wstrb 4'b1100.
